// File: rtl/axilite_csr_write_resp.sv
// axilite_csr_write_resp
// AXI4-Lite slave write-response stage. Per-write response codes from the
// write-data stage are queued in a small FIFO and issued on the B channel in
// acceptance order. resp_ready provides backpressure while the master stalls
// bready.
// Optional build macro: AXILITE_CSR_WRITE_RESP_ERRCNT_EN adds a saturating
// 16-bit err_count of SLVERR/DECERR B handshakes.
module axilite_csr_write_resp #(
  parameter int RESP_DEPTH  = 2,
  parameter int RESP_OKAY   = 0,
  parameter int RESP_EXOKAY = 1,
  parameter int RESP_SLVERR = 2,
  parameter int RESP_DECERR = 3
) (
  input  logic        clk,
  input  logic        rst,
`ifdef AXILITE_CSR_WRITE_RESP_ERRCNT_EN
  output logic [15:0] err_count,
`endif
  input  logic [3:0]  resp,
  input  logic        resp_valid,
  output logic        resp_ready,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RESP_DEPTH);
  localparam logic [1:0]       OKAY_C   = 2'(RESP_OKAY);
  localparam logic [1:0]       EXOKAY_C = 2'(RESP_EXOKAY);
  localparam logic [1:0]       SLVERR_C = 2'(RESP_SLVERR);
  localparam logic [1:0]       DECERR_C = 2'(RESP_DECERR);

  // A code with nonzero upper bits, or one outside the four AXI encodings,
  // is reported to the master as a slave error.
  function automatic logic [1:0] sanitize_code(input logic [3:0] code);
    logic [1:0] c;
    c = code[1:0];
    if (code[3:2] != 2'b00) return SLVERR_C;
    if (c == OKAY_C || c == EXOKAY_C || c == SLVERR_C || c == DECERR_C) return c;
    return SLVERR_C;
  endfunction

  logic [1:0]       mem_q [RESP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // Handshake status is derived from registered count only, so neither
  // resp_ready nor bvalid has a combinational path from the inputs.
  assign resp_ready = (count_q != DEPTH_C);
  assign bvalid     = (count_q != '0);
  assign bresp      = bvalid ? mem_q[rd_ptr_q] : OKAY_C;

  assign push = resp_valid && resp_ready;
  assign pop  = bvalid && bready;

  // Next-state for pointers and occupancy; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; async reset flushes the queue and drops bvalid at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Response storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sanitize_code(resp);
  end

`ifdef AXILITE_CSR_WRITE_RESP_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  function automatic logic is_err(input logic [1:0] code);
    return (code == SLVERR_C) || (code == DECERR_C);
  endfunction

  // Saturating count of error responses actually handed to the master.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (pop && is_err(bresp) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule
